a23_cache_axi4_fill: RTL and testbench

//  Line-fill engine directly downstream of the a23 cache's bus-side request port.

---
 rtl/a23_fill_pkg.sv | 17 +
 rtl/a23_cache_axi4_fill.sv | 125 ++++++++++++
 tb/tb_a23_cache_axi4_fill.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/a23_fill_pkg.sv
// Shared AXI encodings and fill-engine state type for the a23 cache line-fill path.
package a23_fill_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DONE
  } fill_state_t;

endpackage

// File: rtl/a23_cache_axi4_fill.sv
// Turns one a23 cache miss into a single AXI4 read burst of one line, returning words one per beat.
// Optional macro A23_FILL_CRITICAL_WORD_FIRST_EN: word-aligned WRAP burst starting at the missed word.
module a23_cache_axi4_fill
  import a23_fill_pkg::*;
#(
  parameter int         CACHE_WORDS_PER_LINE = 4,
  parameter logic [3:0] AXI_ID               = 4'd0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        o_stall,
  output logic [31:0] o_read_data,
  output logic        o_read_data_valid,
  output logic        o_err,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready
);

  localparam int            CW       = (CACHE_WORDS_PER_LINE > 1) ? $clog2(CACHE_WORDS_PER_LINE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(CACHE_WORDS_PER_LINE - 1);

`ifdef A23_FILL_CRITICAL_WORD_FIRST_EN
  localparam logic [31:0] ADDR_MASK = ~32'd3;
  localparam logic [1:0]  BURST     = AXI_BURST_WRAP;
`else
  localparam logic [31:0] ADDR_MASK = ~(32'(CACHE_WORDS_PER_LINE * 4) - 32'd1);
  localparam logic [1:0]  BURST     = AXI_BURST_INCR;
`endif

  fill_state_t   state;
  logic [CW-1:0] beat_cnt;
  logic          overrun;
  logic          err_flag;
  logic          at_last_idx;
  logic          beat_err;

  assign o_arid    = AXI_ID;
  assign o_arlen   = 8'(CACHE_WORDS_PER_LINE - 1);
  assign o_arsize  = AXI_SIZE_4B;
  assign o_arburst = BURST;

  // Stall rises in the very cycle the miss is presented so the cache freezes before the burst starts.
  assign o_stall = (state == AR) || (state == R) || ((state == IDLE) && i_req);

  // A beat is malformed if it carries a bad response or rlast disagrees with being the final line word.
  always_comb begin
    at_last_idx = !overrun && (beat_cnt == LAST_IDX);
    beat_err    = (i_rresp != AXI_RESP_OKAY) || (i_rlast != at_last_idx);
  end

  // Single-burst sequencer; every outward-facing handshake and data signal is registered here.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state             <= IDLE;
      o_araddr          <= '0;
      o_arvalid         <= 1'b0;
      o_rready          <= 1'b0;
      o_read_data       <= '0;
      o_read_data_valid <= 1'b0;
      o_err             <= 1'b0;
      beat_cnt          <= '0;
      overrun           <= 1'b0;
      err_flag          <= 1'b0;
    end else begin
      o_read_data_valid <= 1'b0;
      o_err             <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            o_araddr  <= i_address & ADDR_MASK;
            o_arvalid <= 1'b1;
            beat_cnt  <= '0;
            overrun   <= 1'b0;
            err_flag  <= 1'b0;
            state     <= AR;
          end
        end
        AR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (i_rvalid && o_rready) begin
            // Beats past the end of the line are drained but never handed to the cache.
            if (!overrun) begin
              o_read_data       <= i_rdata;
              o_read_data_valid <= 1'b1;
            end
            if (beat_cnt == LAST_IDX) begin
              overrun <= 1'b1;
            end
            beat_cnt <= beat_cnt + 1'b1;
            err_flag <= err_flag || beat_err;
            if (i_rlast) begin
              o_rready <= 1'b0;
              o_err    <= err_flag || beat_err;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a23_cache_axi4_fill.sv
// Randomized self-checking bench for a23_cache_axi4_fill with a behavioural line-fill model.
// Honors A23_FILL_CRITICAL_WORD_FIRST_EN when the same macro is defined for the bench.
module tb_a23_cache_axi4_fill;

  localparam int W = 4;

`ifdef A23_FILL_CRITICAL_WORD_FIRST_EN
  localparam logic [31:0] ALIGN_MASK = ~32'd3;
  localparam logic [1:0]  EXP_BURST  = 2'b10;
`else
  localparam logic [31:0] ALIGN_MASK = ~32'(W * 4 - 1);
  localparam logic [1:0]  EXP_BURST  = 2'b01;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] address = '0;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        stall;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        rready;

  a23_cache_axi4_fill #(.CACHE_WORDS_PER_LINE(W), .AXI_ID(4'd0)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_req(req), .i_address(address),
    .o_stall(stall), .o_read_data(read_data), .o_read_data_valid(read_data_valid),
    .o_err(err), .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready), .i_rdata(rdata),
    .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model of the current fill: line words the cache must see, error outcome, request address.
  logic [31:0] exp_words[$];
  logic        exp_err = 1'b0;
  logic [31:0] exp_araddr = '0;
  logic        in_burst = 1'b0;
  int          ar_cycles = 0;
  int          rdv_count = 0;
  int          err_pulses = 0;
  logic [31:0] last_araddr = '0;
  logic [1:0]  last_arburst = '0;

  logic        pend_valid = 1'b0;
  logic        pend_err = 1'b0;
  logic        pend_done = 1'b0;
  int          beat_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model; handshakes seen now set expectations for the next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_stall", stall, 0);
      check("rst_rdv", read_data_valid, 0);
      check("rst_err", err, 0);
      check("rst_rdata", read_data, 0);
      pend_valid = 1'b0;
      pend_err   = 1'b0;
      pend_done  = 1'b0;
      beat_idx   = 0;
    end else begin
      check("rdv", read_data_valid, pend_valid);
      if (pend_valid) begin
        rdv_count++;
        if (exp_words.size() == 0) check("rdata_unexpected", read_data, 32'hDEAD_BEEF);
        else check("rdata", read_data, exp_words.pop_front());
      end
      check("err", err, pend_err);
      if (err) err_pulses++;
      if (pend_done) begin
        check("stall_done", stall, 0);
        check("rready_done", rready, 0);
      end
      if (in_burst) check("stall_busy", stall, 1);
      if (arvalid) begin
        ar_cycles++;
        last_araddr  = araddr;
        last_arburst = arburst;
        check("araddr", araddr, exp_araddr);
        check("arlen", arlen, W - 1);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, EXP_BURST);
        check("arid", arid, 0);
        check("rready_in_ar", rready, 0);
      end
      pend_valid = 1'b0;
      pend_err   = 1'b0;
      pend_done  = 1'b0;
      if (rvalid && rready) begin
        pend_valid = (beat_idx < W);
        beat_idx++;
        if (rlast) begin
          pend_err  = exp_err;
          pend_done = 1'b1;
          in_burst  = 1'b0;
          beat_idx  = 0;
        end
      end
    end
  end

  // One complete fill as seen from the cache and the AXI slave; abort_at >= 0 resets after that many beats.
  task automatic apply_stimulus(input logic [31:0] addr, input int delay, input int nbeats,
                                input int bad_beat, input logic [1:0] bad_resp,
                                input int gap_lo, input int gap_hi, input logic fixed_data,
                                input int first_word, input logic noise, input int abort_at);
    logic [31:0] d;
    int gap;
    exp_araddr = addr & ALIGN_MASK;
    exp_err    = (nbeats != W) || (bad_beat >= 0 && bad_beat < nbeats);
    ar_cycles  = 0;
    req        = 1'b1;
    address    = addr;
    #1;
    check("stall_comb", stall, 1);
    step();
    in_burst = 1'b1;
    req      = 1'b0;
    check("arvalid_next", arvalid, 1);
    for (int k = 0; k < delay; k++) begin
      if (noise) begin
        req     = 1'($urandom);
        address = $urandom;
      end
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rready_r", rready, 1);
    check("ar_cycles", ar_cycles, delay + 1);
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_at) begin
        rvalid = 1'b0;
        req    = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("abort_arvalid", arvalid, 0);
        check("abort_rready", rready, 0);
        check("abort_stall", stall, 0);
        check("abort_rdv", read_data_valid, 0);
        check("abort_err", err, 0);
        check("abort_rdata", read_data, 0);
        exp_words.delete();
        in_burst = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      gap = $urandom_range(gap_hi, gap_lo);
      if (i == 0) gap = 0;
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        if (noise) begin
          req     = 1'($urandom);
          address = $urandom;
        end
        step();
      end
      d = fixed_data ? 32'hA0 + 32'((first_word + i) % W) : $urandom;
      if (i < W) exp_words.push_back(d);
      rvalid = 1'b1;
      rdata  = d;
      rresp  = (i == bad_beat) ? bad_resp : 2'b00;
      rlast  = (i == nbeats - 1);
      if (noise) req = 1'($urandom);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    req    = 1'b0;
    step();
    step();
    check("words_left", exp_words.size(), 0);
  endtask

  initial begin
    int v0, e0, n, r, bb;
    logic [1:0] br;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    v0 = rdv_count; e0 = err_pulses;
    $display("[TB] basic fill");
    apply_stimulus(32'h1004, 0, 4, -1, 2'b00, 0, 0, 1'b1, 0, 1'b0, -1);
    check("t1_valids", rdv_count - v0, 4);
    check("t1_err", err_pulses - e0, 0);
`ifndef A23_FILL_CRITICAL_WORD_FIRST_EN
    check("t1_araddr", last_araddr, 32'h1000);
    check("t1_arburst", last_arburst, 2'b01);
`endif

    $display("[TB] arready stalled");
    apply_stimulus(32'h0000_3450, 5, 4, -1, 2'b00, 0, 0, 1'b0, 0, 1'b0, -1);
    check("t2_ar_cycles", ar_cycles, 6);

    $display("[TB] rvalid gaps");
    apply_stimulus(32'h0000_4000, 1, 4, -1, 2'b00, 2, 2, 1'b0, 0, 1'b0, -1);

    v0 = rdv_count; e0 = err_pulses;
    $display("[TB] slave error");
    apply_stimulus(32'h0000_5008, 0, 4, 1, 2'b10, 0, 1, 1'b0, 0, 1'b0, -1);
    check("t4_valids", rdv_count - v0, 4);
    check("t4_err_pulses", err_pulses - e0, 1);

    $display("[TB] reset mid-burst");
    apply_stimulus(32'h0000_6000, 0, 4, -1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 2);
    v0 = rdv_count;
    apply_stimulus(32'h2000, 0, 4, -1, 2'b00, 0, 1, 1'b0, 0, 1'b0, -1);
    check("t5_valids", rdv_count - v0, 4);
`ifndef A23_FILL_CRITICAL_WORD_FIRST_EN
    check("t5_araddr", last_araddr, 32'h2000);
`endif

`ifdef A23_FILL_CRITICAL_WORD_FIRST_EN
    $display("[TB] critical word first");
    apply_stimulus(32'h1008, 0, 4, -1, 2'b00, 0, 0, 1'b1, 2, 1'b0, -1);
    check("t6_araddr", last_araddr, 32'h1008);
    check("t6_arburst", last_arburst, 2'b10);
`endif

    $display("[TB] randomized fills");
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(9, 0);
      n = (r == 0) ? $urandom_range(3, 1) : (r == 1) ? $urandom_range(6, 5) : W;
      bb = ($urandom_range(9, 0) < 2) ? $urandom_range(n - 1, 0) : -1;
      br = 2'($urandom_range(3, 1));
      apply_stimulus($urandom, $urandom_range(3, 0), n, bb, br, 0, 2, 1'b0, 0, 1'b1, -1);
      repeat ($urandom_range(2, 0)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
